// File: rtl/mem_req_sched.sv
// mem_req_sched: arbitrates fetch/data requests onto one memory port, tags each with a slot ID
// and routes responses back by ID. Define ARB_STARVE_GUARD_EN to give fetch a guaranteed turn.
package const_pkg;
  localparam int unsigned PA_WIDTH   = 32;
  localparam int unsigned LINE_BYTES = 8;
  localparam int unsigned ID_WIDTH   = 4;
endpackage

module mem_req_sched #(
  parameter int unsigned PA_WIDTH        = const_pkg::PA_WIDTH,
  parameter int unsigned LINE_BYTES      = const_pkg::LINE_BYTES,
  parameter int unsigned ID_WIDTH        = const_pkg::ID_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned STARVE_LIMIT    = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_instr_valid,
  output logic                      o_instr_ready,
  input  logic [PA_WIDTH-1:0]       i_instr_addr,
  input  logic                      i_data_valid,
  output logic                      o_data_ready,
  input  logic [PA_WIDTH-1:0]       i_data_addr,
  input  logic [LINE_BYTES*8-1:0]   i_data_wdata,
  input  logic                      i_data_write,
  output logic                      o_mem_enable,
  input  logic                      i_mem_ready,
  output logic [PA_WIDTH-1:0]       o_mem_addr,
  output logic [LINE_BYTES*8-1:0]   o_mem_data,
  output logic                      o_mem_write,
  output logic [ID_WIDTH-1:0]       o_mem_id,
  input  logic                      i_mem_resp_valid,
  input  logic [ID_WIDTH-1:0]       i_mem_resp_id,
  input  logic [LINE_BYTES*8-1:0]   i_mem_resp_data,
  output logic                      o_instr_resp_valid,
  output logic                      o_data_resp_valid,
  output logic [LINE_BYTES*8-1:0]   o_resp_data,
  output logic                      o_err
);

  localparam int unsigned DW    = LINE_BYTES * 8;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {
    SRC_INSTR = 1'b0,
    SRC_DATA  = 1'b1
  } src_e;

  if (MAX_OUTSTANDING < 1 || 64'(MAX_OUTSTANDING) > (64'd1 << ID_WIDTH)) begin : g_bad_outstanding
    $error("mem_req_sched: MAX_OUTSTANDING must be in 1..2**ID_WIDTH");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_starve
    $error("mem_req_sched: STARVE_LIMIT must be at least 1");
  end

  logic [MAX_OUTSTANDING-1:0] slot_vld_q, slot_vld_d;
  src_e                       slot_src_q [MAX_OUTSTANDING];
  src_e                       slot_src_d [MAX_OUTSTANDING];
  logic [CNT_W-1:0]           count_q, count_d;

  logic                       mem_en_q, mem_en_d;
  logic [PA_WIDTH-1:0]        mem_addr_q, mem_addr_d;
  logic [DW-1:0]              mem_data_q, mem_data_d;
  logic                       mem_write_q, mem_write_d;
  logic [ID_WIDTH-1:0]        mem_id_q, mem_id_d;

  logic                       irv_q, irv_d;
  logic                       drv_q, drv_d;
  logic [DW-1:0]              rdata_q, rdata_d;
  logic                       err_q, err_d;

  logic                       full, stall, can_accept, force_instr, data_win;
  logic                       instr_acc, data_acc, accept;
  logic                       free_hit;
  src_e                       resp_src;
  logic [ID_WIDTH-1:0]        alloc_id;

  assign full       = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign stall      = mem_en_q && !i_mem_ready;
  assign can_accept = !full && !stall;

  // The winner is decided before acceptance so the loser never sees ready.
  assign data_win      = i_data_valid && !force_instr;
  assign o_data_ready  = can_accept && data_win;
  assign o_instr_ready = can_accept && !data_win;
  assign data_acc      = i_data_valid && o_data_ready;
  assign instr_acc     = i_instr_valid && o_instr_ready;
  assign accept        = data_acc || instr_acc;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);

  logic [STV_W-1:0] starve_q, starve_d;

  assign force_instr = i_instr_valid && (starve_q >= STV_W'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (instr_acc) begin
      starve_d = '0;
    end else if (i_instr_valid && can_accept && (starve_q < STV_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_instr = 1'b0;
`endif

  // Lowest free slot wins; a slot freed this cycle is still marked valid here.
  always_comb begin
    alloc_id = '0;
    for (int unsigned i = MAX_OUTSTANDING; i > 0; i--) begin
      if (!slot_vld_q[i-1]) begin
        alloc_id = ID_WIDTH'(i - 1);
      end
    end
  end

  always_comb begin
    free_hit = 1'b0;
    resp_src = SRC_INSTR;
    for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
      if (i_mem_resp_valid && slot_vld_q[i] && (i_mem_resp_id == ID_WIDTH'(i))) begin
        free_hit = 1'b1;
        resp_src = slot_src_q[i];
      end
    end
  end

  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_src_d = slot_src_q;
    for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
      if (free_hit && (i_mem_resp_id == ID_WIDTH'(i))) begin
        slot_vld_d[i] = 1'b0;
      end
      if (accept && (alloc_id == ID_WIDTH'(i))) begin
        slot_vld_d[i] = 1'b1;
        slot_src_d[i] = data_acc ? SRC_DATA : SRC_INSTR;
      end
    end
    count_d = count_q + CNT_W'(accept) - CNT_W'(free_hit);
  end

  always_comb begin
    mem_en_d    = mem_en_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_write_d = mem_write_q;
    mem_id_d    = mem_id_q;
    if (accept) begin
      mem_en_d    = 1'b1;
      mem_addr_d  = data_acc ? i_data_addr : i_instr_addr;
      mem_data_d  = data_acc ? i_data_wdata : '0;
      mem_write_d = data_acc && i_data_write;
      mem_id_d    = alloc_id;
    end else if (i_mem_ready) begin
      mem_en_d    = 1'b0;
    end
  end

  always_comb begin
    irv_d   = free_hit && (resp_src == SRC_INSTR);
    drv_d   = free_hit && (resp_src == SRC_DATA);
    err_d   = i_mem_resp_valid && !free_hit;
    rdata_d = free_hit ? i_mem_resp_data : rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_vld_q  <= '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        slot_src_q[i] <= SRC_INSTR;
      end
      count_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_write_q <= 1'b0;
      mem_id_q    <= '0;
      irv_q       <= 1'b0;
      drv_q       <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      slot_vld_q  <= slot_vld_d;
      slot_src_q  <= slot_src_d;
      count_q     <= count_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_write_q <= mem_write_d;
      mem_id_q    <= mem_id_d;
      irv_q       <= irv_d;
      drv_q       <= drv_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign o_mem_enable       = mem_en_q;
  assign o_mem_addr         = mem_addr_q;
  assign o_mem_data         = mem_data_q;
  assign o_mem_write        = mem_write_q;
  assign o_mem_id           = mem_id_q;
  assign o_instr_resp_valid = irv_q;
  assign o_data_resp_valid  = drv_q;
  assign o_resp_data        = rdata_q;
  assign o_err              = err_q;

endmodule

// File: tb/tb_mem_req_sched.sv
// Self-checking bench for mem_req_sched: directed scenarios plus randomized traffic against a
// transaction-level model of outstanding IDs, issue register and response routing.
module tb_mem_req_sched;

  localparam int unsigned PAW    = 32;
  localparam int unsigned LB     = 8;
  localparam int unsigned IDW    = 4;
  localparam int unsigned MAXO   = 4;
  localparam int unsigned STARVE = 3;
  localparam int unsigned DW     = LB * 8;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           i_instr_valid, o_instr_ready;
  logic [PAW-1:0] i_instr_addr;
  logic           i_data_valid, o_data_ready;
  logic [PAW-1:0] i_data_addr;
  logic [DW-1:0]  i_data_wdata;
  logic           i_data_write;
  logic           o_mem_enable, i_mem_ready;
  logic [PAW-1:0] o_mem_addr;
  logic [DW-1:0]  o_mem_data;
  logic           o_mem_write;
  logic [IDW-1:0] o_mem_id;
  logic           i_mem_resp_valid;
  logic [IDW-1:0] i_mem_resp_id;
  logic [DW-1:0]  i_mem_resp_data;
  logic           o_instr_resp_valid, o_data_resp_valid;
  logic [DW-1:0]  o_resp_data;
  logic           o_err;

  mem_req_sched #(
    .PA_WIDTH(PAW), .LINE_BYTES(LB), .ID_WIDTH(IDW),
    .MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(STARVE)
  ) dut (
    .clk(clk), .rst(rst),
    .i_instr_valid(i_instr_valid), .o_instr_ready(o_instr_ready), .i_instr_addr(i_instr_addr),
    .i_data_valid(i_data_valid), .o_data_ready(o_data_ready), .i_data_addr(i_data_addr),
    .i_data_wdata(i_data_wdata), .i_data_write(i_data_write),
    .o_mem_enable(o_mem_enable), .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr),
    .o_mem_data(o_mem_data), .o_mem_write(o_mem_write), .o_mem_id(o_mem_id),
    .i_mem_resp_valid(i_mem_resp_valid), .i_mem_resp_id(i_mem_resp_id),
    .i_mem_resp_data(i_mem_resp_data),
    .o_instr_resp_valid(o_instr_resp_valid), .o_data_resp_valid(o_data_resp_valid),
    .o_resp_data(o_resp_data), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // stimulus for the next cycle
  logic           t_iv, t_dv, t_dwr, t_mr, t_rv;
  logic [PAW-1:0] t_ia, t_da;
  logic [DW-1:0]  t_dwd, t_rd;
  logic [IDW-1:0] t_rid;
  bit             acc_i, acc_d;

  // reference model: outstanding id -> source (1 = data), ids already handed to memory
  bit             m_src[int];
  bit             m_iss[int];
  bit             m_busy;
  logic [PAW-1:0] m_addr;
  logic [DW-1:0]  m_data;
  bit             m_wr;
  int             m_id;
  int             m_starve;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_src.delete();
    m_iss.delete();
    m_busy   = 1'b0;
    m_id     = 0;
    m_starve = 0;
  endtask

  task automatic cycle();
    bit            full, can, force_i, dwin, e_irv, e_drv, e_err;
    logic [DW-1:0] e_rd;
    int            slot;
    int            rid;
    i_instr_valid    = t_iv;
    i_instr_addr     = t_ia;
    i_data_valid     = t_dv;
    i_data_addr      = t_da;
    i_data_wdata     = t_dwd;
    i_data_write     = t_dwr;
    i_mem_ready      = t_mr;
    i_mem_resp_valid = t_rv;
    i_mem_resp_id    = t_rid;
    i_mem_resp_data  = t_rd;
    #1;
    full    = (m_src.num() == MAXO);
    can     = !full && !(m_busy && !t_mr);
    force_i = GUARD && t_iv && (m_starve >= STARVE);
    dwin    = t_dv && !force_i;
    if (t_dv) chk("data_ready", o_data_ready, can && dwin);
    if (t_iv) chk("instr_ready", o_instr_ready, can && !dwin);
    acc_d = t_dv && can && dwin;
    acc_i = t_iv && can && !dwin;

    slot = 0;
    while (m_src.exists(slot)) slot++;
    e_irv = 1'b0; e_drv = 1'b0; e_err = 1'b0; e_rd = '0;
    rid = int'(t_rid);
    if (t_rv) begin
      if (m_src.exists(rid)) begin
        if (m_src[rid]) e_drv = 1'b1; else e_irv = 1'b1;
        e_rd = t_rd;
        m_src.delete(rid);
        m_iss.delete(rid);
      end else begin
        e_err = 1'b1;
      end
    end
    if (m_busy && t_mr) begin
      if (m_src.exists(m_id)) m_iss[m_id] = 1'b1;
      m_busy = 1'b0;
    end
    if (acc_i || acc_d) begin
      m_src[slot] = acc_d;
      m_busy = 1'b1;
      m_id   = slot;
      m_addr = acc_d ? t_da : t_ia;
      m_data = acc_d ? t_dwd : '0;
      m_wr   = acc_d && t_dwr;
    end
    if (acc_i) m_starve = 0;
    else if (t_iv && can) m_starve++;

    @(posedge clk);
    #1;
    chk("mem_enable", o_mem_enable, m_busy);
    if (m_busy) begin
      chk("mem_addr", o_mem_addr, m_addr);
      chk("mem_data", o_mem_data, m_data);
      chk("mem_write", o_mem_write, m_wr);
      chk("mem_id", o_mem_id, m_id);
    end
    chk("instr_resp_valid", o_instr_resp_valid, e_irv);
    chk("data_resp_valid", o_data_resp_valid, e_drv);
    chk("err", o_err, e_err);
    if (e_irv || e_drv) chk("resp_data", o_resp_data, e_rd);
  endtask

  // respond to everything outstanding while letting any held request through
  task automatic drain();
    int ks[$];
    int guard = 0;
    t_mr = 1'b1;
    while ((m_src.num() > 0 || m_busy || t_iv || t_dv) && guard < 40) begin
      ks.delete();
      foreach (m_iss[k]) ks.push_back(k);
      t_rv = (ks.size() > 0);
      if (t_rv) begin
        t_rid = IDW'(ks[0]);
        t_rd  = {$urandom, $urandom};
      end
      cycle();
      if (acc_i) t_iv = 1'b0;
      if (acc_d) t_dv = 1'b0;
      guard++;
    end
    t_rv = 1'b0;
    chk("drain_bound", guard < 40, 1'b1);
  endtask

  initial begin
    logic [PAW-1:0] e6;
    int             ks[$];
    rst = 1'b1;
    t_iv = 0; t_dv = 0; t_dwr = 0; t_mr = 1; t_rv = 0;
    t_ia = '0; t_da = '0; t_dwd = '0; t_rd = '0; t_rid = '0;
    i_instr_valid = 0; i_instr_addr = '0; i_data_valid = 0; i_data_addr = '0;
    i_data_wdata = '0; i_data_write = 0; i_mem_ready = 1; i_mem_resp_valid = 0;
    i_mem_resp_id = '0; i_mem_resp_data = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_enable", o_mem_enable, 1'b0);
    chk("rst_mem_addr", o_mem_addr, '0);
    chk("rst_mem_data", o_mem_data, '0);
    chk("rst_mem_write", o_mem_write, 1'b0);
    chk("rst_mem_id", o_mem_id, '0);
    chk("rst_instr_resp", o_instr_resp_valid, 1'b0);
    chk("rst_data_resp", o_data_resp_valid, 1'b0);
    chk("rst_resp_data", o_resp_data, '0);
    chk("rst_err", o_err, 1'b0);
    rst = 1'b0;

    // single instruction read
    t_iv = 1; t_ia = 32'h100; cycle();
    chk("t1_mem_id", o_mem_id, 0);
    chk("t1_mem_addr", o_mem_addr, 32'h100);
    chk("t1_mem_write", o_mem_write, 1'b0);
    chk("t1_mem_data", o_mem_data, '0);
    t_iv = 0; cycle();
    t_rv = 1; t_rid = 0; t_rd = 64'hDEAD_BEEF_0123_4567; cycle();
    chk("t1_instr_resp", o_instr_resp_valid, 1'b1);
    chk("t1_data_resp", o_data_resp_valid, 1'b0);
    chk("t1_resp_data", o_resp_data, 64'hDEAD_BEEF_0123_4567);
    t_rv = 0; cycle();
    chk("t1_resp_pulse", o_instr_resp_valid, 1'b0);

    // simultaneous requests: data first, then instr
    t_iv = 1; t_ia = 32'h200; t_dv = 1; t_da = 32'h300; t_dwr = 0; t_dwd = '0; cycle();
    chk("t2_first_addr", o_mem_addr, 32'h300);
    chk("t2_first_id", o_mem_id, 0);
    t_dv = 0; cycle();
    chk("t2_second_addr", o_mem_addr, 32'h200);
    chk("t2_second_id", o_mem_id, 1);
    t_iv = 0; drain();

    // fill to capacity, free id 2, reuse it
    for (int k = 0; k < 4; k++) begin
      t_dv = 1; t_da = 32'h1000 + 32'(k * 64); t_dwr = 0; t_dwd = {$urandom, $urandom};
      cycle();
      chk("t3_fill_id", o_mem_id, k);
    end
    t_dv = 1; t_da = 32'h2000; t_rv = 1; t_rid = 2; t_rd = 64'h0BAD_CAFE_5555_AAAA;
    i_data_valid = 1'b1; i_data_addr = t_da;
    #1;
    chk("t3_full_ready", o_data_ready, 1'b0);
    cycle();
    chk("t3_resp2_data", o_data_resp_valid, 1'b1);
    t_rv = 0; cycle();
    chk("t3_reuse_id", o_mem_id, 2);
    chk("t3_reuse_addr", o_mem_addr, 32'h2000);
    t_dv = 0; drain();

    // memory stall for five cycles
    t_dv = 1; t_da = 32'h3000; t_dwr = 1; t_dwd = 64'h1111_2222_3333_4444; t_mr = 1; cycle();
    t_dv = 1; t_da = 32'h3040; t_dwr = 0; t_dwd = '0; t_iv = 1; t_ia = 32'h3080; t_mr = 0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("t4_enable", o_mem_enable, 1'b1);
      chk("t4_addr", o_mem_addr, 32'h3000);
      chk("t4_data", o_mem_data, 64'h1111_2222_3333_4444);
      chk("t4_write", o_mem_write, 1'b1);
      chk("t4_id", o_mem_id, 0);
    end
    t_mr = 1; cycle();
    chk("t4_next_addr", o_mem_addr, 32'h3040);
    if (acc_d) t_dv = 0;
    drain();

    // unknown response id
    t_iv = 1; t_ia = 32'h4000; cycle();
    t_iv = 0;
    chk("t5_id", o_mem_id, 0);
    t_rv = 1; t_rid = 3; t_rd = 64'h7777; cycle();
    chk("t5_err", o_err, 1'b1);
    chk("t5_instr_resp", o_instr_resp_valid, 1'b0);
    chk("t5_data_resp", o_data_resp_valid, 1'b0);
    t_rv = 0; cycle();
    chk("t5_err_pulse", o_err, 1'b0);
    drain();

    // starvation: data valid every cycle with instr waiting
    t_iv = 1; t_ia = 32'h5000;
    for (int k = 0; k < 4; k++) begin
      t_dv = 1; t_da = 32'h6000 + 32'(k * 64); t_dwr = 0; t_dwd = '0;
      cycle();
      e6 = (GUARD && k == 3) ? 32'h5000 : 32'h6000 + 32'(k * 64);
      chk("t6_grant_addr", o_mem_addr, e6);
      if (acc_i) t_iv = 0;
    end
    if (acc_d) t_dv = 0;
    drain();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      if (!t_iv) begin
        t_iv = ($urandom_range(0, 2) == 0);
        t_ia = $urandom;
      end
      if (!t_dv) begin
        t_dv  = ($urandom_range(0, 1) == 1);
        t_da  = $urandom;
        t_dwd = {$urandom, $urandom};
        t_dwr = ($urandom_range(0, 1) == 1);
      end
      t_mr = ($urandom_range(0, 3) != 0);
      t_rv = 0;
      if ($urandom_range(0, 2) == 0) begin
        ks.delete();
        foreach (m_iss[k]) ks.push_back(k);
        if (ks.size() > 0 && $urandom_range(0, 7) != 0)
          t_rid = IDW'(ks[$urandom_range(0, ks.size() - 1)]);
        else
          t_rid = IDW'($urandom_range(0, 15));
        t_rv = 1;
        t_rd = {$urandom, $urandom};
      end
      cycle();
      if (acc_i) t_iv = 0;
      if (acc_d) t_dv = 0;
    end
    t_rv = 0;
    drain();

    // reset with a request outstanding
    t_dv = 1; t_da = 32'h7000; t_dwr = 0; t_mr = 1; cycle();
    t_dv = 0;
    rst = 1'b1;
    #1;
    chk("rst_mid_enable", o_mem_enable, 1'b0);
    chk("rst_mid_addr", o_mem_addr, '0);
    chk("rst_mid_id", o_mem_id, '0);
    model_reset();
    t_iv = 0; t_rv = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    t_rv = 1; t_rid = 0; t_rd = 64'h1234; cycle();
    chk("rst_mid_err", o_err, 1'b1);
    chk("rst_mid_data_resp", o_data_resp_valid, 1'b0);
    t_rv = 0; cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
